// File: rtl/instr_decode_exec_if.sv
// Instruction-in / result-out stream bundle for instr_decode_exec.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
interface instr_decode_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [15:0]      out_opcode;
  logic             out_err;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_result, out_opcode, out_err
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_result, out_opcode, out_err
  );
endinterface

// File: rtl/instr_decode_exec.sv
// Decodes {opcode, operands} words, executes against a persistent base register,
// and returns one response per accepted word; POW iterates one multiply per cycle.
module instr_decode_exec #(
   parameter int WIDTH    = 32,
   parameter int EXP_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_decode_exec_if.slave    bus,
   output logic                  busy,
   output logic [1:0]            o_state
);

   localparam logic [15:0] OP_NOP  = 16'h0000;
   localparam logic [15:0] OP_LOAD = 16'h0001;
   localparam logic [15:0] OP_POW  = 16'h0002;
   localparam logic [15:0] OP_ADD  = 16'h0003;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [WIDTH-1:0]    r_base;
   logic [WIDTH-1:0]    r_acc;
   logic [EXP_BITS-1:0] r_cnt;
   logic [WIDTH-1:0]    r_result;
   logic [15:0]         r_opcode;
   logic                r_err;

   logic                w_accept;
   logic [15:0]         w_opcode;
   logic [WIDTH-1:0]    w_operand;
   logic [WIDTH-1:0]    w_prod;

   assign w_accept  = bus.in_valid && (r_state == S_IDLE);
   assign w_opcode  = bus.in_instr[31:16];
   assign w_operand = WIDTH'(bus.in_instr[15:0]);
   assign w_prod    = r_acc * r_base;

   // Handshake flags come only from registered state, so in_ready never depends on out_ready.
   assign bus.in_ready   = (r_state == S_IDLE);
   assign bus.out_valid  = (r_state == S_RESP);
   assign bus.out_result = r_result;
   assign bus.out_opcode = r_opcode;
   assign bus.out_err    = r_err;
   assign busy           = (r_state != S_IDLE);
   assign o_state        = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = (w_opcode == OP_POW) ? S_EXEC : S_RESP;
         S_EXEC: if (r_cnt == '0) w_next_state = S_RESP;
         S_RESP: if (bus.out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_base   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_opcode <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_opcode <= w_opcode;
                  r_err    <= 1'b0;
                  case (w_opcode)
                     OP_NOP:  r_result <= '0;
                     OP_LOAD: begin
                        r_base   <= w_operand;
                        r_result <= w_operand;
                     end
                     OP_POW: begin
                        r_acc <= WIDTH'(1'b1);
                        r_cnt <= bus.in_instr[EXP_BITS-1:0];
                     end
                     OP_ADD:  r_result <= r_base + w_operand;
                     default: begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                     end
                  endcase
               end
            end
            // One multiply per cycle; the cnt==0 cycle publishes acc, giving e+1 EXEC cycles.
            S_EXEC: begin
               if (r_cnt != '0) begin
                  r_acc <= w_prod;
                  r_cnt <= r_cnt - EXP_BITS'(1);
               end else begin
                  r_result <= r_acc;
                  r_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
